// File: rtl/sdpram_gen2_pkg.sv
// sdpram_gen2 shared types and helpers.
// Optional lane parity is enabled by SDPRAM_GEN2_PARITY_EN.
package sdpram_gen2_pkg;

   typedef enum logic {INIT, RUN} state_t;

   localparam int MAX_BYTE = 9;

   function automatic int be_width(input int dw, input int bs);
      return dw / bs;
   endfunction

   // even parity over the low bs bits of a lane
   function automatic logic lane_parity(input logic [MAX_BYTE-1:0] data,
                                        input int bs);
      logic p;
      p = 1'b0;
      for (int i = 0; i < MAX_BYTE; i++)
         if (i < bs) p = p ^ data[i];
      return p;
   endfunction

endpackage

// File: rtl/sdpram_gen2_if.sv
// Write/read request bundle for sdpram_gen2.
// rd_parity_err is only meaningful with SDPRAM_GEN2_PARITY_EN.
interface sdpram_gen2_if
   import sdpram_gen2_pkg::*;
#(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_SIZE  = 8
);
   localparam int BE_WIDTH = be_width(DATA_WIDTH, BYTE_SIZE);

   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [BE_WIDTH-1:0]   wr_byte_en;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  init_busy;
   logic [BE_WIDTH-1:0]   rd_parity_err;

   modport master (
      output wr_en, wr_addr, wr_data, wr_byte_en,
      output rd_en, rd_addr,
      input  rd_data, rd_valid, init_busy, rd_parity_err
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_byte_en,
      input  rd_en, rd_addr,
      output rd_data, rd_valid, init_busy, rd_parity_err
   );

endinterface

// File: rtl/sdpram_gen2_mem.sv
// Raw storage: per-lane write port, one registered read port.
// Parity array exists only when PAR_EN (set from SDPRAM_GEN2_PARITY_EN).
module sdpram_gen2_mem
   import sdpram_gen2_pkg::*;
#(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_SIZE  = 8,
   parameter bit PAR_EN     = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [DATA_WIDTH/BYTE_SIZE-1:0] i_wbe,
   input  logic [DATA_WIDTH/BYTE_SIZE-1:0] i_wpar,
   input  logic                  i_re,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic [DATA_WIDTH/BYTE_SIZE-1:0] o_rpar
);
   localparam int BE_WIDTH = be_width(DATA_WIDTH, BYTE_SIZE);
   localparam int DEPTH    = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      if (i_we)
         for (int i = 0; i < BE_WIDTH; i++)
            if (i_wbe[i])
               r_mem[i_waddr][i*BYTE_SIZE +: BYTE_SIZE] <=
                  i_wdata[i*BYTE_SIZE +: BYTE_SIZE];
   end

   always_ff @(posedge clk) begin
      if (rst)       r_q <= '0;
      else if (i_re) r_q <= r_mem[i_raddr];
   end

   assign o_rdata = r_q;

   if (PAR_EN) begin : g_par
      logic [BE_WIDTH-1:0] r_par [DEPTH];
      logic [BE_WIDTH-1:0] r_pq;

      always_ff @(posedge clk) begin
         if (i_we)
            for (int i = 0; i < BE_WIDTH; i++)
               if (i_wbe[i]) r_par[i_waddr][i] <= i_wpar[i];
      end

      always_ff @(posedge clk) begin
         if (rst)       r_pq <= '0;
         else if (i_re) r_pq <= r_par[i_raddr];
      end

      assign o_rpar = r_pq;
   end else begin : g_nopar
      logic w_unused;
      assign w_unused = ^i_wpar;
      assign o_rpar   = '0;
   end

endmodule

// File: rtl/sdpram_gen2.sv
// Simple dual-port RAM: clear sequencer, write-first forwarding, 1/2-cycle read.
// Define SDPRAM_GEN2_PARITY_EN for per-lane even parity storage and checking.
module sdpram_gen2
   import sdpram_gen2_pkg::*;
#(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_SIZE  = 8,
   parameter int OUTPUT_REG = 0,
   parameter int INIT_CLEAR = 1
) (
   input logic           clk,
   input logic           rst,
   sdpram_gen2_if.slave  bus
);
   localparam int BE_WIDTH = be_width(DATA_WIDTH, BYTE_SIZE);
   localparam int DEPTH    = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
`ifdef SDPRAM_GEN2_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   state_t                r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_clr_addr, w_clr_nxt;
   logic                  w_we, w_re, w_hit;
   logic [ADDR_WIDTH-1:0] w_waddr;
   logic [DATA_WIDTH-1:0] w_wdata, w_mem_q, w_merged;
   logic [BE_WIDTH-1:0]   w_wbe, w_wpar, w_mem_par, w_perr;
   logic [BE_WIDTH-1:0]   r_fwd_be;
   logic [DATA_WIDTH-1:0] r_fwd_data;
   logic                  r_v1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= (INIT_CLEAR != 0) ? INIT : RUN;
         r_clr_addr <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_clr_addr <= w_clr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_clr_nxt   = r_clr_addr;
      w_we        = 1'b0;
      w_re        = 1'b0;
      w_waddr     = bus.wr_addr;
      w_wdata     = bus.wr_data;
      w_wbe       = bus.wr_byte_en;
      unique case (r_state)
         INIT: begin
            w_we      = 1'b1;
            w_waddr   = r_clr_addr;
            w_wdata   = '0;
            w_wbe     = '1;
            w_clr_nxt = r_clr_addr + 1'b1;
            if (r_clr_addr == LAST) w_state_nxt = RUN;
         end
         RUN: begin
            w_we = bus.wr_en;
            w_re = bus.rd_en;
         end
      endcase
      if (rst) begin
         w_we = 1'b0;
         w_re = 1'b0;
      end
   end

   always_comb begin
      w_wpar = '0;
      for (int i = 0; i < BE_WIDTH; i++)
         w_wpar[i] = lane_parity(
            MAX_BYTE'(w_wdata[i*BYTE_SIZE +: BYTE_SIZE]), BYTE_SIZE);
   end

   sdpram_gen2_mem #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .BYTE_SIZE  (BYTE_SIZE),
      .PAR_EN     (PAR_EN)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_wbe   (w_wbe),
      .i_wpar  (w_wpar),
      .i_re    (w_re),
      .i_raddr (bus.rd_addr),
      .o_rdata (w_mem_q),
      .o_rpar  (w_mem_par)
   );

   // same-edge collision: remember which lanes take the incoming write data
   assign w_hit = w_we & w_re & (bus.wr_addr == bus.rd_addr);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fwd_be   <= '0;
         r_fwd_data <= '0;
         r_v1       <= 1'b0;
      end else begin
         r_v1 <= w_re;
         if (w_re) begin
            r_fwd_be   <= w_hit ? bus.wr_byte_en : '0;
            r_fwd_data <= bus.wr_data;
         end
      end
   end

   always_comb begin
      w_merged = w_mem_q;
      w_perr   = '0;
      for (int i = 0; i < BE_WIDTH; i++) begin
         if (r_fwd_be[i])
            w_merged[i*BYTE_SIZE +: BYTE_SIZE] =
               r_fwd_data[i*BYTE_SIZE +: BYTE_SIZE];
         w_perr[i] = PAR_EN & ~r_fwd_be[i] & (w_mem_par[i] ^ lane_parity(
            MAX_BYTE'(w_mem_q[i*BYTE_SIZE +: BYTE_SIZE]), BYTE_SIZE));
      end
   end

   assign bus.init_busy = (r_state == INIT);

   if (OUTPUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] r_out;
      logic [BE_WIDTH-1:0]   r_perr;
      logic                  r_v2;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_out  <= '0;
            r_perr <= '0;
            r_v2   <= 1'b0;
         end else begin
            r_v2   <= r_v1;
            r_perr <= r_v1 ? w_perr : '0;
            if (r_v1) r_out <= w_merged;
         end
      end

      assign bus.rd_data       = r_out;
      assign bus.rd_valid      = r_v2;
      assign bus.rd_parity_err = r_perr;
   end else begin : g_direct
      assign bus.rd_data       = w_merged;
      assign bus.rd_valid      = r_v1;
      assign bus.rd_parity_err = r_v1 ? w_perr : '0;
   end

endmodule

// File: tb/tb_sdpram_gen2.sv
// Directed bench for sdpram_gen2: latency-1 and latency-2 instances side by side.
// Build with +define+SDPRAM_GEN2_PARITY_EN to exercise the parity path.
module tb_sdpram_gen2;
   import sdpram_gen2_pkg::*;

   localparam int AW = 4;
   localparam int DW = 32;
   localparam int BS = 8;
`ifdef SDPRAM_GEN2_PARITY_EN
   localparam logic [3:0] EXP_PERR = 4'b0010;
`else
   localparam logic [3:0] EXP_PERR = 4'b0000;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sdpram_gen2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SIZE(BS)) bus0 ();
   sdpram_gen2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SIZE(BS)) bus1 ();

   sdpram_gen2 #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SIZE(BS),
      .OUTPUT_REG(0), .INIT_CLEAR(1)
   ) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

   sdpram_gen2 #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SIZE(BS),
      .OUTPUT_REG(1), .INIT_CLEAR(1)
   ) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

   typedef struct {
      logic        we;
      logic [3:0]  wa;
      logic [31:0] wd;
      logic [3:0]  be;
      logic        re;
      logic [3:0]  ra;
      logic        ev;
      logic [31:0] ed;
   } vec_t;

   vec_t vecs [16];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [3:0] wa,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic re, input logic [3:0] ra);
      bus0.wr_en = we; bus0.wr_addr = wa; bus0.wr_data = wd;
      bus0.wr_byte_en = be; bus0.rd_en = re; bus0.rd_addr = ra;
      bus1.wr_en = we; bus1.wr_addr = wa; bus1.wr_data = wd;
      bus1.wr_byte_en = be; bus1.rd_en = re; bus1.rd_addr = ra;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic init_wait(input string name);
      int cnt;
      int pulses;
      cnt = 0;
      pulses = 0;
      while (bus0.init_busy && cnt < 100) begin
         tick();
         cnt++;
         if (bus0.rd_valid) pulses++;
      end
      chk({name, "_busy_cycles"}, 32'(cnt), 32'd16);
      chk({name, "_valid_in_init"}, 32'(pulses), 32'd0);
      chk({name, "_busy1_done"}, 32'(bus1.init_busy), 32'd0);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 4'h3, 32'hDEADBEEF, 4'hF, 1'b0, 4'h0, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 4'h3, 32'h11223344, 4'h5, 1'b0, 4'h0, 1'b0, 32'h0};
      vecs[2]  = '{1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h3, 1'b1, 32'hDE22BE44};
      vecs[3]  = '{1'b1, 4'h5, 32'h12345678, 4'hF, 1'b0, 4'h0,
                   1'b0, 32'hDE22BE44};
      vecs[4]  = '{1'b1, 4'h5, 32'hAAAAAAAA, 4'h3, 1'b1, 4'h5,
                   1'b1, 32'h1234AAAA};
      vecs[5]  = '{1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h5, 1'b1, 32'h1234AAAA};
      vecs[6]  = '{1'b1, 4'h7, 32'hCAFEF00D, 4'h0, 1'b1, 4'h7, 1'b1, 32'h0};
      vecs[7]  = '{1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h7, 1'b1, 32'h0};
      vecs[8]  = '{1'b1, 4'h0, 32'h01020304, 4'hF, 1'b0, 4'h0, 1'b0, 32'h0};
      vecs[9]  = '{1'b1, 4'h1, 32'hA5A5A5A5, 4'hF, 1'b0, 4'h0, 1'b0, 32'h0};
      vecs[10] = '{1'b1, 4'h2, 32'h0F0F0F0F, 4'hF, 1'b0, 4'h0, 1'b0, 32'h0};
      vecs[11] = '{1'b1, 4'hF, 32'hFFFFFFFF, 4'h8, 1'b1, 4'hF,
                   1'b1, 32'hFF000000};
      vecs[12] = '{1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'hF, 1'b1, 32'hFF000000};
      vecs[13] = '{1'b1, 4'hF, 32'h000000AB, 4'h1, 1'b1, 4'hE, 1'b1, 32'h0};
      vecs[14] = '{1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'hF, 1'b1, 32'hFF0000AB};
      vecs[15] = '{1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0, 32'hFF0000AB};

      // reset state
      drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
      rst = 1'b1;
      tick();
      tick();
      chk("rst_data0", bus0.rd_data, 32'h0);
      chk("rst_valid0", 32'(bus0.rd_valid), 32'd0);
      chk("rst_busy0", 32'(bus0.init_busy), 32'd1);
      chk("rst_perr0", 32'(bus0.rd_parity_err), 32'd0);
      chk("rst_data1", bus1.rd_data, 32'h0);
      chk("rst_valid1", 32'(bus1.rd_valid), 32'd0);
      chk("rst_busy1", 32'(bus1.init_busy), 32'd1);

      // clear sequence with requests that must be ignored
      rst = 1'b0;
      drive(1'b1, 4'h0, 32'h5A5A5A5A, 4'hF, 1'b1, 4'h0);
      init_wait("init1");
      drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);

      for (int a = 0; a < 16; a++) begin
         drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'(a));
         tick();
         chk($sformatf("clr_valid_%0d", a), 32'(bus0.rd_valid), 32'd1);
         chk($sformatf("clr_data_%0d", a), bus0.rd_data, 32'h0);
      end

      for (int v = 0; v < 16; v++) begin
         drive(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].be,
               vecs[v].re, vecs[v].ra);
         tick();
         chk($sformatf("vec%0d_valid", v), 32'(bus0.rd_valid), 32'(vecs[v].ev));
         chk($sformatf("vec%0d_data", v), bus0.rd_data, vecs[v].ed);
         chk($sformatf("vec%0d_perr", v), 32'(bus0.rd_parity_err), 32'd0);
      end

      // back-to-back reads; latency 2 on dut1; in-flight read sees old data
      drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h0);
      tick();
      chk("b2b0_d0", bus0.rd_data, 32'h01020304);
      chk("b2b0_v1", 32'(bus1.rd_valid), 32'd0);
      chk("b2b0_d1", bus1.rd_data, 32'hFF0000AB);
      drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h1);
      tick();
      chk("b2b1_d0", bus0.rd_data, 32'hA5A5A5A5);
      chk("b2b1_v1", 32'(bus1.rd_valid), 32'd1);
      chk("b2b1_d1", bus1.rd_data, 32'h01020304);
      drive(1'b1, 4'h1, 32'h77777777, 4'hF, 1'b1, 4'h2);
      tick();
      chk("b2b2_d0", bus0.rd_data, 32'h0F0F0F0F);
      chk("b2b2_v1", 32'(bus1.rd_valid), 32'd1);
      chk("b2b2_d1", bus1.rd_data, 32'hA5A5A5A5);
      drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
      tick();
      chk("b2b3_v0", 32'(bus0.rd_valid), 32'd0);
      chk("b2b3_d0", bus0.rd_data, 32'h0F0F0F0F);
      chk("b2b3_v1", 32'(bus1.rd_valid), 32'd1);
      chk("b2b3_d1", bus1.rd_data, 32'h0F0F0F0F);
      tick();
      chk("b2b4_v1", 32'(bus1.rd_valid), 32'd0);
      chk("b2b4_d1", bus1.rd_data, 32'h0F0F0F0F);
      drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h1);
      tick();
      chk("late_wr_d0", bus0.rd_data, 32'h77777777);

      // corrupt one stored bit behind the parity
      dut0.u_mem.r_mem[2][9] <= ~dut0.u_mem.r_mem[2][9];
      drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h2);
      tick();
      chk("par_d0", bus0.rd_data, 32'h0F0F0D0F);
      chk("par_err0", 32'(bus0.rd_parity_err), 32'(EXP_PERR));
      drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
      tick();
      chk("par_err0_idle", 32'(bus0.rd_parity_err), 32'd0);
      chk("par_d1", bus1.rd_data, 32'h0F0F0F0F);
      chk("par_err1", 32'(bus1.rd_parity_err), 32'd0);

      // reset in the middle of the clear sequence
      rst = 1'b1;
      tick();
      chk("rst2_data0", bus0.rd_data, 32'h0);
      chk("rst2_busy0", 32'(bus0.init_busy), 32'd1);
      rst = 1'b0;
      for (int k = 0; k < 7; k++) tick();
      chk("mid_busy0", 32'(bus0.init_busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1'b1, 4'h0, 32'hFFFFFFFF, 4'hF, 1'b1, 4'h0);
      init_wait("init2");
      drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h0);
      tick();
      chk("post_a0_valid", 32'(bus0.rd_valid), 32'd1);
      chk("post_a0_data", bus0.rd_data, 32'h0);
      drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h3);
      tick();
      chk("post_a3_data", bus0.rd_data, 32'h0);
      drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'hF);
      tick();
      chk("post_a15_data", bus0.rd_data, 32'h0);
      drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
